// File: rtl/pipelined_tree_multiplier_if.sv
// Operand/result handshake bundle for pipelined_tree_multiplier.
// The master side issues operands and consumes results; the slave side is the multiplier.
interface pipelined_tree_multiplier_if #(
  parameter int unsigned WIDTH = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   x;
  logic [WIDTH-1:0]   y;
  logic               is_signed;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] o;
  logic               o_signed;

  modport master (
    output in_valid, x, y, is_signed, out_ready,
    input  in_ready, out_valid, o, o_signed
  );

  modport slave (
    input  in_valid, x, y, is_signed, out_ready,
    output in_ready, out_valid, o, o_signed
  );
endinterface

// File: rtl/pipelined_tree_multiplier.sv
// Three-stage pipelined WIDTH x WIDTH multiplier (unsigned or Baugh-Wooley signed per beat).
// S1: partial products, S2: carry-save pair, S3: prefix-adder sum; valid/ready on both sides.
module pipelined_tree_multiplier #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          SIGNED_EN = 1'b1
) (
  input logic                        clk,
  input logic                        rst,
  pipelined_tree_multiplier_if.slave bus
);
  localparam int unsigned PW  = 2 * WIDTH;
  localparam int unsigned NR  = WIDTH + 1;
  localparam int unsigned LVL = $clog2(PW);

  logic s1_v_q, s1_v_d, s2_v_q, s2_v_d, s3_v_q, s3_v_d;
  logic s1_adv, s2_adv, s3_adv;
  logic in_fire, ld2, ld3;

  logic [NR-1:0][PW-1:0] pp_q, pp_d;
  logic                  s1_sgn_q, s1_sgn_d;
  logic [PW-1:0]         sum_q, sum_d, cry_q, cry_d;
  logic                  s2_sgn_q, s2_sgn_d;
  logic [PW-1:0]         o_q, o_d;
  logic                  o_signed_q, o_signed_d;
  logic                  sgn_c;

  // Stall chain: a stage moves when its successor is empty or moving.
  always_comb begin
    s3_adv  = ~s3_v_q | bus.out_ready;
    s2_adv  = ~s2_v_q | s3_adv;
    s1_adv  = ~s1_v_q | s2_adv;
    in_fire = bus.in_valid & s1_adv;
    ld2     = s2_adv & s1_v_q;
    ld3     = s3_adv & s2_v_q;
    s1_v_d  = s1_adv ? bus.in_valid : s1_v_q;
    s2_v_d  = s2_adv ? s1_v_q : s2_v_q;
    s3_v_d  = s3_adv ? s2_v_q : s3_v_q;
  end

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s3_v_q;
  assign bus.o         = o_q;
  assign bus.o_signed  = o_signed_q;

  // S1: AND matrix; in signed mode the MSB row/column terms are inverted (corner kept)
  // and a constant row adds 1s at columns WIDTH and PW-1.
  always_comb begin
    sgn_c    = SIGNED_EN & bus.is_signed;
    pp_d     = pp_q;
    s1_sgn_d = s1_sgn_q;
    if (in_fire) begin
      pp_d     = '0;
      s1_sgn_d = sgn_c;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        for (int unsigned j = 0; j < WIDTH; j++) begin
          pp_d[i][i+j] = (bus.x[j] & bus.y[i]) ^
                         (sgn_c & ((i == WIDTH - 1) != (j == WIDTH - 1)));
        end
      end
      if (sgn_c) begin
        pp_d[WIDTH][WIDTH]  = 1'b1;
        pp_d[WIDTH][PW-1]   = 1'b1;
      end
    end
  end

  // S2: 3:2 compressor rows fold the partial products into a carry-save pair.
  always_comb begin : csa_reduce
    logic [PW-1:0] s, c, t;
    s = pp_q[0];
    c = pp_q[1];
    for (int unsigned r = 2; r < NR; r++) begin
      t = (s & c) | (s & pp_q[r]) | (c & pp_q[r]);
      s = s ^ c ^ pp_q[r];
      c = t << 1;
    end
    sum_d    = sum_q;
    cry_d    = cry_q;
    s2_sgn_d = s2_sgn_q;
    if (ld2) begin
      sum_d    = s;
      cry_d    = c;
      s2_sgn_d = s1_sgn_q;
    end
  end

  // S3: Kogge-Stone generate/propagate prefix adder on the carry-save pair.
  always_comb begin : prefix_add
    logic [PW-1:0] g, p, gt, pt;
    g = sum_q & cry_q;
    p = sum_q ^ cry_q;
    for (int unsigned l = 0; l < LVL; l++) begin
      gt = g;
      pt = p;
      for (int unsigned i = (1 << l); i < PW; i++) begin
        g[i] = gt[i] | (pt[i] & gt[i - (1 << l)]);
        p[i] = pt[i] & pt[i - (1 << l)];
      end
    end
    o_d        = o_q;
    o_signed_d = o_signed_q;
    if (ld3) begin
      o_d        = (sum_q ^ cry_q) ^ {g[PW-2:0], 1'b0};
      o_signed_d = s2_sgn_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q     <= 1'b0;
      s2_v_q     <= 1'b0;
      s3_v_q     <= 1'b0;
      pp_q       <= '0;
      s1_sgn_q   <= 1'b0;
      sum_q      <= '0;
      cry_q      <= '0;
      s2_sgn_q   <= 1'b0;
      o_q        <= '0;
      o_signed_q <= 1'b0;
    end else begin
      s1_v_q     <= s1_v_d;
      s2_v_q     <= s2_v_d;
      s3_v_q     <= s3_v_d;
      pp_q       <= pp_d;
      s1_sgn_q   <= s1_sgn_d;
      sum_q      <= sum_d;
      cry_q      <= cry_d;
      s2_sgn_q   <= s2_sgn_d;
      o_q        <= o_d;
      o_signed_q <= o_signed_d;
    end
  end
endmodule

// File: doc/pipelined_tree_multiplier.md
Name: pipelined_tree_multiplier

Overview:
- Parametrised, pipelined successor to the fixed 4-bit combinational tree multiplier.
- Computes the full-width product of two WIDTH-bit operands, unsigned or two's-complement signed, selected per transaction.
- The partial-product tree and the final prefix adder are split across 3 register stages, with valid/ready handshakes on both sides.
- Sits between an operand-issuing datapath and a result consumer that may apply backpressure.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..32; product width is 2*WIDTH.
- SIGNED_EN, 1, when 0 the signed mode is disabled and the is_signed input is ignored (treated as 0).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts the beat this cycle.
- x  input  WIDTH  multiplicand.
- y  input  WIDTH  multiplier.
- is_signed  input  1  1 = both operands are two's complement; 0 = both unsigned.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts the result this cycle.
- o  output  2*WIDTH  product.
- o_signed  output  1  echo of the is_signed value used for this result.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: all stage valid bits = 0, out_valid = 0, o = 0, o_signed = 0, in_ready = 1 on the first cycle after reset deasserts.
- Handshake rules:
  - Input transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
  - x, y and is_signed are sampled only on an input transfer.
  - Once out_valid is asserted, o and o_signed stay stable until the output transfer completes.
- Pipeline, stages S1..S3, each holding a valid bit plus its data:
  - S1 registers the AND partial products. For signed mode, Baugh-Wooley correction is applied: MSB-row and MSB-column terms are inverted, and constant 1s are added at columns WIDTH and 2*WIDTH-1.
  - S2 registers the carry-save pair (two 2*WIDTH rows) produced by the HA/FA column-compression tree.
  - S3 registers the sum of the two rows from the prefix (generate/propagate) adder. S3 drives o and out_valid.
- Latency is exactly 3 cycles from the input transfer to out_valid, given no backpressure.
- Throughput is 1 result per cycle when out_ready is held high.
- Stall rules:
  - Stage k advances when stage k+1 is empty or is advancing in the same cycle.
  - S3 advances when out_ready = 1 or S3 is empty.
  - in_ready = ~S1.valid | S1 advances. in_ready is therefore combinationally dependent on out_ready through the chain; no skid buffer is used.
  - If all three stages are full and out_ready = 0, in_ready = 0. No beat is lost or duplicated.
- Simultaneous events: an input transfer and an output transfer in the same cycle with a full pipeline are both accepted, and occupancy stays at 3.
- Arithmetic:
  - The result is an exact product modulo 2^(2*WIDTH); no overflow is possible at full width.
  - Unsigned range: 0..(2^WIDTH-1)^2.
  - Signed: the most negative value times the most negative value (e.g. -8*-8 at WIDTH=4) yields the correct +2^(2*WIDTH-2).
  - is_signed travels with its own data; mode can change on every beat without a flush.
- Idle: when in_valid = 0, bubbles propagate and the stage data registers may hold stale values. o is only meaningful while out_valid = 1.
- Reset mid-operation: all in-flight beats are discarded immediately (asynchronously), out_valid drops to 0 without a handshake, and no result from before the reset appears afterwards.

Test Plan:
1. Exhaustive at WIDTH=4, unsigned then signed, out_ready=1, back-to-back input beats:
   - 15*15 -> o=8'hE1.
   - signed 4'h8*4'h8 -> 8'h40.
   - signed 4'hF*4'h7 -> 8'hF9.
   - All 512 pairs must match the reference model.
   - out_valid must rise exactly 3 cycles after the first input transfer.
2. Backpressure:
   - Hold out_ready=0 while driving 5 beats (1*1, 2*3, 3*5, 4*7, 5*9).
   - in_ready must drop after 3 are accepted.
   - o must hold 8'h01 stable.
   - Then release out_ready and expect, in order, 01, 06, 0F, 1C, 2D with no gaps.
3. Mixed mode per beat:
   - Alternate is_signed 1/0 with x=4'hE, y=4'h3.
   - Expect alternating results 8'hFA (signed) and 8'h2A (unsigned), each with the matching o_signed.
4. Reset mid-flight:
   - Accept 2 beats, then assert rst for 1 cycle.
   - out_valid must go to 0 immediately.
   - No result may appear for the next 5 cycles with in_valid=0.
   - A new beat 3*3 must return 8'h09 after exactly 3 cycles.
5. Randomised throughput at WIDTH=16, SIGNED_EN=1, over 10k beats:
   - Drive random in_valid and out_ready.
   - Scoreboard: every result matches and arrives in order, with no drop or duplicate.
   - Include 16'h8000*16'h8000 signed -> 32'h40000000.
6. SIGNED_EN=0, WIDTH=8:
   - is_signed=1 with x=8'hFF, y=8'hFF -> o=16'hFE01 and o_signed=0.
